// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the shared regfile write port, with a pending-destination scoreboard.
// Optional build macro WB_BYPASS_EN adds the byp_valid/byp_dst/byp_data forwarding outputs.
module wb_port_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 64,
   parameter int RW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*RW-1:0] req_dst,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic             wb_hold,
   output logic             wb_en,
   output logic [RW-1:0]    wb_dst,
   output logic [DW-1:0]    wb_data,
   input  logic             sb_set,
   input  logic [RW-1:0]    sb_reg,
   output logic [15:0]      pending
`ifdef WB_BYPASS_EN
   ,
   output logic             byp_valid,
   output logic [RW-1:0]    byp_dst,
   output logic [DW-1:0]    byp_data
`endif
);
   localparam int PW = $clog2(NREQ);
   logic [PW-1:0] rr_ptr, gidx, idx;
   logic          xfer;
   logic [RW-1:0] gdst;
   logic [DW-1:0] gdata;
   logic [15:0]   pend_nx;
   // scan from the highest rotated offset down so the last hit is the first valid at or after rr_ptr
   always_comb begin
      gidx = '0;
      idx  = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr) + k) % NREQ);
         if (req_valid[idx]) gidx = idx;
      end
   end
   assign req_ready = (|req_valid && !wb_hold && !reset) ? NREQ'(1) << gidx : '0;
   assign xfer      = |(req_valid & req_ready);
   assign gdst      = req_dst[gidx*RW +: RW];
   assign gdata     = req_data[gidx*DW +: DW];
   // a new issue to the same register overrides the clear from the write now retiring
   always_comb begin
      pend_nx = pending;
      if (wb_en) pend_nx[wb_dst] = 1'b0;
      if (sb_set) pend_nx[sb_reg] = 1'b1;
   end
`ifdef WB_BYPASS_EN
   assign byp_valid = xfer;
   assign byp_dst   = gdst;
   assign byp_data  = gdata;
`endif
   // registered write stage, round-robin pointer and scoreboard state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_en   <= 1'b0;
         wb_dst  <= '0;
         wb_data <= '0;
         rr_ptr  <= '0;
         pending <= '0;
      end else begin
         wb_en   <= xfer;
         pending <= pend_nx;
         if (xfer) begin
            wb_dst  <= gdst;
            wb_data <= gdata;
            rr_ptr  <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
         end
      end
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single 64-bit register-file write port (16 x 64-bit GPRs, RAX..R15) among NREQ execution-unit requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered write stage drives the regfile write port.
- Keeps a 16-bit pending-destination scoreboard that issue logic uses for RAW stall checks.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
DW, 64, data width of a register write
RW, 4, register index width (16 GPRs)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  requester i has a result pending
req_ready  output  NREQ  grant to requester i; transfer occurs when valid && ready
req_dst  input  NREQ*RW  destination register of requester i, slice [i*RW +: RW]
req_data  input  NREQ*DW  result of requester i, slice [i*DW +: DW]
wb_hold  input  1  regfile port unavailable this cycle; no grant issued
wb_en  output  1  registered write enable to the register file
wb_dst  output  RW  registered destination index
wb_data  output  DW  registered write data
sb_set  input  1  issue marks a destination as pending
sb_reg  input  RW  register index for sb_set
pending  output  16  scoreboard; bit r = 1 means a write to r is outstanding

Behaviour:
- Reset (async, any time): wb_en=0, wb_dst=0, wb_data=0, pending=0, rr_ptr=0, req_ready=0. An in-flight registered write is discarded.
- Arbitration (combinational, same cycle):
  - If wb_hold=1 or no req_valid is set: req_ready=0.
  - Otherwise grant exactly one requester: the first valid index searching rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ..., rr_ptr-1.
  - req_ready is one-hot or zero. req_ready never asserts for a requester with req_valid=0.
- Pointer update: on a transfer by requester g, rr_ptr <= g+1. When g=NREQ-1, rr_ptr wraps to 0. rr_ptr is unchanged when there is no transfer.
- Write stage:
  - Latency is 1 cycle. A transfer at edge k gives wb_en=1 with the granted dst/data during cycle k+1.
  - wb_en=0 in any cycle after a cycle with no transfer.
  - wb_dst/wb_data hold their last value when wb_en=0.
- Throughput: one write per cycle; back-to-back grants are allowed.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Scoreboard:
  - Set: pending[sb_reg] <= 1 on sb_set.
  - Clear: pending[wb_dst] <= 0 at the edge ending a cycle in which wb_en=1, i.e. when the write reaches the regfile.
  - Simultaneous set and clear of the same register: set wins. A new producer was issued, so the bit stays 1.
  - Set of an already-pending register: the bit stays 1. Single outstanding writer per register is a protocol rule for issue; no counting.
- Requester rules:
  - req_dst/req_data must stay stable while req_valid=1 and not granted.
  - A requester may drop valid only after its transfer. The block does not check this.
- wb_hold has no effect on a write already registered: wb_en in the next cycle still reflects the previous transfer.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, adds outputs byp_valid (1), byp_dst (RW), byp_data (DW).
  - These are combinational copies of the granted request in the transfer cycle: byp_valid = |(req_valid & req_ready).
  - Issue logic can forward the result one cycle before the regfile write.
  - byp_valid=0 during reset.
- When undefined, these ports do not exist and the forwarding logic is not built.
- Arbitration and scoreboard behaviour are identical in both builds.

Test Plan:
- Reset mid-operation: assert reset while wb_en=1 (dst=5, data=0xDEAD) and pending=0x0020 -> wb_en=0, pending=0x0000, rr_ptr=0 immediately, without waiting for a clock edge.
- Single request: req_valid=3'b010, dst=3, data=0x1234 -> req_ready=3'b010 same cycle; next cycle wb_en=1, wb_dst=3, wb_data=0x1234; following cycle wb_en=0.
- Round-robin: all three valid for 6 cycles starting rr_ptr=0 -> grant order 0,1,2,0,1,2; wb_en held at 1 for 6 consecutive cycles.
- Hold: wb_hold=1 for 2 cycles with req_valid=3'b001 -> req_ready=0 both cycles, then grant on the first cycle with wb_hold=0; rr_ptr unchanged during hold.
- Scoreboard clear: sb_set with sb_reg=7, then a requester writes dst=7 -> pending[7]=1 until the edge ending the wb_en=1 cycle, then 0.
- Scoreboard set/clear collision: sb_set with sb_reg=7 in the same cycle as wb_en=1, wb_dst=7 -> pending[7] remains 1. With WB_BYPASS_EN, byp_valid=1 and byp_dst=7 in the grant cycle.
